// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with hex display and leading-zero blanking.
// Define SEG7_DECIMAL_EN to add the sequential double-dabble decimal mode.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int DATA_W      = 16,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     value,
   input  logic                  value_valid,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] Anode_Activate,
   output logic [6:0]            LED_out
);

   localparam int BUF_W = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int EXT_W = DATA_W + BUF_W;

   logic [CNT_W-1:0] refresh_cnt;
   logic [IDX_W-1:0] digit_idx;
   logic [BUF_W-1:0] disp_buf;
   logic [EXT_W-1:0] value_ext;
   logic [BUF_W-1:0] hex_digits;
   logic             hex_ovf;
   logic             hex_accept;
   logic             commit;
   logic [BUF_W-1:0] bcd;
   logic             sticky;

   // Zero-extend so narrow values pad the upper digits and wide values expose truncated bits.
   assign value_ext  = EXT_W'(value);
   assign hex_digits = value_ext[BUF_W-1:0];
   assign hex_ovf    = |(value_ext >> BUF_W);

`ifdef SEG7_DECIMAL_EN
   // state    | meaning
   // S_IDLE   | accepting loads
   // S_SHIFT  | one double-dabble step per cycle, DATA_W cycles
   // S_COMMIT | copy BCD result and sticky overflow into the display
   localparam int BITS_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   shreg;
   logic [BUF_W-1:0]    bcd_adj;
   logic [BITS_W-1:0]   bit_cnt;
   logic                dec_accept;

   assign busy       = (state != S_IDLE);
   assign dec_accept = value_valid && !busy && dec_mode;
   assign hex_accept = value_valid && !busy && !dec_mode;
   assign commit     = (state == S_COMMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (dec_accept) state_nxt = S_SHIFT;
         S_SHIFT:  if (bit_cnt == BITS_W'(1)) state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bcd     <= '0;
         sticky  <= 1'b0;
         bit_cnt <= '0;
      end else if (dec_accept) begin
         shreg   <= value;
         bcd     <= '0;
         sticky  <= 1'b0;
         bit_cnt <= BITS_W'(DATA_W);
      end else if (state == S_SHIFT) begin
         shreg   <= {shreg[DATA_W-2:0], 1'b0};
         bcd     <= {bcd_adj[BUF_W-2:0], shreg[DATA_W-1]};
         sticky  <= sticky | bcd_adj[BUF_W-1];
         bit_cnt <= bit_cnt - 1'b1;
      end
   end
`else
   logic unused_dec_mode;

   assign unused_dec_mode = dec_mode;
   assign busy            = 1'b0;
   assign hex_accept      = value_valid;
   assign commit          = 1'b0;
   assign bcd             = '0;
   assign sticky          = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_buf <= '0;
         overflow <= 1'b0;
      end else if (hex_accept) begin
         disp_buf <= hex_digits;
         overflow <= hex_ovf;
      end else if (commit) begin
         disp_buf <= bcd;
         overflow <= sticky;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'h0: seg_code = 7'b0000001;
         4'h1: seg_code = 7'b1001111;
         4'h2: seg_code = 7'b0010010;
         4'h3: seg_code = 7'b0000110;
         4'h4: seg_code = 7'b1001100;
         4'h5: seg_code = 7'b0100100;
         4'h6: seg_code = 7'b0100000;
         4'h7: seg_code = 7'b0001111;
         4'h8: seg_code = 7'b0000000;
         4'h9: seg_code = 7'b0000100;
         4'hA: seg_code = 7'b0001000;
         4'hB: seg_code = 7'b1100000;
         4'hC: seg_code = 7'b0110001;
         4'hD: seg_code = 7'b1000010;
         4'hE: seg_code = 7'b0110000;
         default: seg_code = 7'b0111000;
      endcase
   endfunction

   logic [IDX_W-1:0]      lead_idx;
   logic [3:0]            cur_digit;
   logic                  blank_cur;
   logic [6:0]            seg_nxt;
   logic [NUM_DIGITS-1:0] anode_nxt;

   // Digit 0 is the floor of lead_idx, so it is never blanked.
   always_comb begin
      lead_idx = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (disp_buf[4*i +: 4] != 4'd0) lead_idx = IDX_W'(i);
      end
      cur_digit = disp_buf[4*digit_idx +: 4];
      blank_cur = blank_lz && (digit_idx > lead_idx);
      if (overflow)       seg_nxt = 7'b1111110;
      else if (blank_cur) seg_nxt = 7'b1111111;
      else                seg_nxt = seg_code(cur_digit);
      anode_nxt = ~(NUM_DIGITS'(1) << digit_idx);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Anode_Activate <= '1;
         LED_out        <= 7'b1111111;
      end else begin
         Anode_Activate <= anode_nxt;
         LED_out        <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed and random loads checked against a digit-level model.
module tb_seg7_scan_ctrl;

   localparam int ND = 4;
   localparam int DW = 16;
   localparam int RD = 4;

`ifdef SEG7_DECIMAL_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   localparam logic [6:0] SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] value = '0;
   logic          value_valid = 1'b0;
   logic          dec_mode = 1'b0;
   logic          blank_lz = 1'b0;
   logic          busy;
   logic          overflow;
   logic [ND-1:0] Anode_Activate;
   logic [6:0]    LED_out;

   int total = 0;
   int bad = 0;
   int n_edge;
   int m_dig [ND];
   bit m_ovf;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
      .dec_mode(dec_mode), .blank_lz(blank_lz), .busy(busy), .overflow(overflow),
      .Anode_Activate(Anode_Activate), .LED_out(LED_out));

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) n_edge <= 0;
      else        n_edge <= n_edge + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int cur_digit();
      return ((n_edge - 1) / RD) % ND;
   endfunction

   function automatic logic [6:0] exp_led(input int d);
      int h = 0;
      for (int i = 0; i < ND; i++) if (m_dig[i] != 0) h = i;
      if (m_ovf) return 7'b1111110;
      if (blank_lz && d > h) return 7'b1111111;
      return SEG[m_dig[d]];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_ovf = 1'b0;
   endtask

   task automatic model_load(input int v, input bit dec);
      if (dec) begin
         m_ovf = (v >= 10 ** ND);
         for (int i = 0; i < ND; i++) m_dig[i] = (v / (10 ** i)) % 10;
      end else begin
         m_ovf = (v >= 16 ** ND);
         for (int i = 0; i < ND; i++) m_dig[i] = (v >> (4 * i)) & 15;
      end
   endtask

   task automatic load(input int v, input bit dec);
      bit eff;
      int cyc;
      eff = dec && DEC_EN;
      @(negedge clk);
      value = DW'(v);
      dec_mode = dec;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value_valid = 1'b0;
      if (eff) begin
         cyc = 0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            check("old_led", LED_out, exp_led(cur_digit()));
         end
         check("busy_len", cyc, 17);
         model_load(v, 1'b1);
      end else begin
         @(negedge clk);
         check("hex_busy", busy, 0);
         model_load(v, 1'b0);
      end
   endtask

   task automatic scan_check(input string tag);
      for (int k = 0; k < ND * RD; k++) begin
         @(negedge clk);
         check({tag, "_an"}, Anode_Activate, 4'hF ^ (1 << cur_digit()));
         check({tag, "_led"}, LED_out, exp_led(cur_digit()));
      end
      check({tag, "_ovf"}, overflow, m_ovf);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int v;
      bit d;
      int cyc;
      model_clear();
      #12;
      check("rst_an", Anode_Activate, 4'hF);
      check("rst_led", LED_out, 7'h7F);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("first_an", Anode_Activate, 4'hE);
      check("first_led", LED_out, 7'b0000001);

      load(32'h1A3F, 1'b0);
      scan_check("hex1a3f");
      load(1234, 1'b1);
      scan_check("dec1234");
      load(65535, 1'b1);
      scan_check("dec65535");

      blank_lz = 1'b1;
      load(7, 1'b0);
      scan_check("blank7");
      load(0, 1'b0);
      scan_check("blank0");
      blank_lz = 1'b0;

`ifdef SEG7_DECIMAL_EN
      @(negedge clk);
      value = DW'(42);
      dec_mode = 1'b1;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value = DW'(99);
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
      end
      value_valid = 1'b0;
      check("ign_busy_len", cyc, 17);
      model_load(42, 1'b1);
      scan_check("dec42");
      load(99, 1'b1);
      scan_check("dec99");
`endif

      @(negedge clk);
      value = DW'(4321);
      dec_mode = 1'b1;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_an", Anode_Activate, 4'hF);
      check("midrst_led", LED_out, 7'h7F);
      check("midrst_ovf", overflow, 0);
      model_clear();
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("rel_an", Anode_Activate, 4'hE);
      check("rel_led", LED_out, 7'b0000001);
      scan_check("post_rst");

      for (int it = 0; it < 8; it++) begin
         blank_lz = 1'($urandom % 2);
         if ($urandom % 2 == 1) v = int'($urandom_range(0, 65535));
         else                   v = int'($urandom_range(0, 300));
         d = 1'($urandom % 2);
         load(v, d);
         scan_check("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
